// File: rtl/mod_mult.sv
// Purpose: 256-bit modular multiplier, product = (a*b) mod params.n, bit-serial
//          interleaved double-and-add from the multiplier MSB down to bit 0.
// Latency: start sampled at edge E0 -> done pulses the cycle after edge E256
//          (256 RUN cycles plus one DONE cycle).
// Backpressure: none; start is ignored while busy, and one more operation may
//          start from DONE on the same edge the result is presented.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : request; a and b are captured on the accepting edge
//   a, b       : operands, each expected to be < params.n
//   busy       : high exactly while the multiplication is running
//   done       : one-cycle pulse when product carries a new result
//   product    : registered result, held until the next result is ready

package elliptic_curve_structs;

  typedef struct packed {
    logic [255:0] n;
  } params_t;

  // Modulus: secp256k1 group order (odd, above 2^255).
  localparam params_t params = '{
    n: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
  };

endpackage

module mod_mult
  import elliptic_curve_structs::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         busy,
  output logic         done,
  output logic [255:0] product
);

  localparam logic [256:0] N_EXT = {1'b0, params.n};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [255:0] a_q, a_d;
  logic [255:0] b_q, b_d;
  logic [255:0] p_q, p_d;
  logic [255:0] product_q, product_d;
  logic [7:0]   i_q, i_d;

  // Datapath for one RUN step.
  logic [256:0] dbl;
  logic [256:0] dbl_sub;
  logic [255:0] dbl_red;
  logic [256:0] sum;
  logic [256:0] sum_sub;
  logic [255:0] p_next;

  // Both intermediates are < 2n and n > 2^255, so in a 257-bit subtraction
  // bit 256 of (x - n) is set exactly when x < n. That bit doubles as the
  // compare result, so no separate magnitude comparator is needed.
  always_comb begin
    dbl     = {p_q, 1'b0};
    dbl_sub = dbl - N_EXT;
    dbl_red = dbl_sub[256] ? dbl[255:0] : dbl_sub[255:0];
    sum     = {1'b0, dbl_red} + (b_q[i_q] ? {1'b0, a_q} : 257'd0);
    sum_sub = sum - N_EXT;
    p_next  = sum_sub[256] ? sum[255:0] : sum_sub[255:0];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    i_d       = i_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          p_d     = '0;
          i_d     = 8'd255;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d = p_next;
        i_d = i_q - 8'd1;
        // The step for bit 0 is the last one; publish its result directly.
        if (i_q == 8'd0) begin
          product_d = p_next;
          state_d   = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      i_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      i_q       <= i_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
